commit_trace_fifo: RTL and testbench
====================================

# commit_trace_fifo

- Consumer at the writeback end of the pipeline's commit interface.
- Each cycle the W stage asserts commit, the block captures one retire record:
  - pc, instr, pre_pc
  - writeback enable, rd and data
  - a sequence number
- Records are buffered in a small FIFO and drained by a trace/difftest reader over a valid/ready handshake.
- Also maintains a free-running retired-instruction counter and a sticky overflow flag.

## Interface
- DEPTH, 8, FIFO entries; power of two, minimum 4
- SEQ_W, 32, width of sequence number and retired counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- regW_i_commit  in  1  one instruction retires this cycle
- regW_i_pc  in  32  PC of retiring instruction
- regW_i_instr  in  32  instruction word
- regW_i_pre_pc  in  32  predicted next PC carried with the instruction
- regW_i_wb_reg_wen  in  1  register write enable
- regW_i_wb_rd  in  5  destination register
- wb_i_valD  in  32  final writeback data (valE/valM already selected)
- trace_i_ready  in  1  reader accepts head record
- trace_i_clr_ovf  in  1  clears sticky overflow
- trace_o_valid  out  1  head record available
- trace_o_pc / trace_o_instr / trace_o_pre_pc  out  32 each  head record fields
- trace_o_wen  out  1  head record writes a register
- trace_o_rd  out  5  head record destination
- trace_o_data  out  32  head record write data
- trace_o_seq  out  SEQ_W  sequence number of head record
- trace_o_count  out  log2(DEPTH)+1  current occupancy
- trace_o_retired  out  SEQ_W  total commits since reset
- trace_o_overflow  out  1  sticky: at least one record dropped

## Operation
**Push.** On a cycle with regW_i_commit=1, a record is written:
- Fields are taken directly from the inputs.
- trace wen = regW_i_wb_reg_wen & (regW_i_wb_rd != 0).
- trace rd and data are forced to 0 when wen=0.
- seq = current trace_o_retired value.

**Pop.** trace_o_valid & trace_i_ready removes the head. Head fields come combinationally from the entry at the read pointer, so the FIFO is first-word-fall-through.

**Pointers.** Read/write pointers are log2(DEPTH)+1 bits and wrap naturally.
- Empty: pointers equal.
- Full: MSBs differ, remaining bits equal.
- count = wptr - rptr, modulo arithmetic.

**Full handling.**
- Commit while full with no pop in the same cycle: the record is dropped and trace_o_overflow is set.
  - trace_o_retired still increments, so the reader detects the gap in seq.
- Commit while full with a pop in the same cycle: the pop frees a slot, the push is accepted, no overflow.
- Commit and pop on an empty FIFO: the pop is ignored because valid=0, and the push is accepted.

**Counters and flags.**
- trace_o_retired increments by 1 on every commit, wrapping at 2^SEQ_W.
- trace_i_clr_ovf clears overflow. If a drop occurs in the same cycle, set wins.
- The reader may hold ready low indefinitely. Head fields must stay stable while valid=1 and ready=0.

## Timing
**Reset values.** On rst, immediately (asynchronous):
- pointers, trace_o_count, trace_o_retired = 0
- trace_o_valid = 0, trace_o_overflow = 0
- head fields read the cleared entry 0, all zero.
- Storage entries are cleared too. rst mid-operation discards all buffered records.

**Latency.**
- A commit at edge N makes the record visible at trace_o_valid after edge N. No same-cycle bypass.
- trace_o_count and trace_o_retired update on the same edge as the push or pop.
- A pop at edge N exposes the next entry immediately after edge N.
- Sustained throughput is one push and one pop per cycle.

## Configuration
- COMMIT_TRACE_STALL_EN defined: adds output trace_o_stall (1 bit, registered, reset 0).
  - trace_o_stall = 1 when the next-cycle occupancy is >= DEPTH-2.
  - It is intended to freeze the pipeline so records are never dropped.
  - Overflow logic remains present.
- Undefined: the port and its logic are absent. The block is lossy under backpressure, as described in Operation.

## Structure
- Shared package commit_pkg holds the record field widths (PC_W=32, INSTR_W=32, RD_W=5) and the packed retire-record layout, so that difftest and trace tooling decode identically.
- One sub-module, commit_trace_mem:
  - DEPTH x record-width register array
  - single write port and combinational read port
  - async clear
- Pointer, counter and flag logic stay in the top.

## Test plan
1. Reset, then 3 commits (pc 0x80000000/04/08, rd 1/2/3, data 0x11/0x22/0x33) with ready=0 → count=3, retired=3, valid=1, head pc=0x80000000, seq=0.
2. Then ready=1 for 3 cycles → records pop in order with seq 0,1,2; count reaches 0; valid drops after the third pop.
3. Commit with rd=0 and wen=1, data 0xDEAD → trace_o_wen=0, rd=0, data=0.
4. Fill DEPTH=8 with ready=0, then 2 more commits → count stays 8, overflow=1, retired=10. After draining, the last seq read is 7; the next commit gets seq 10. Assert clr_ovf → overflow=0.
5. Full FIFO with commit and ready=1 in the same cycle → count stays 8, overflow stays 0, new tail seq = retired-1.
6. Assert rst asynchronously mid-burst with count=5 → all outputs go to 0 before the next edge. With COMMIT_TRACE_STALL_EN defined, reaching occupancy 6 at DEPTH=8 → trace_o_stall=1 the following cycle.

Source files
------------

// File: rtl/commit_pkg.sv
// commit_pkg
//   Shared retire-record definitions for the commit trace path. Difftest and
//   trace tooling decode records using this same packed layout.
//   Contents: field widths, retire_rec_t layout, make_rec() helper that
//   applies the write-enable/rd/data normalisation on capture.
package commit_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned RD_W    = 5;
   localparam int unsigned DATA_W  = 32;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pre_pc;
      logic               wen;
      logic [RD_W-1:0]    rd;
      logic [DATA_W-1:0]  data;
   } retire_rec_t;

   localparam int unsigned REC_W = $bits(retire_rec_t);

   // Writes to x0 are not architectural writes; rd/data are zeroed whenever
   // the record does not write a register so that traces compare cleanly.
   function automatic retire_rec_t make_rec(
      input logic [PC_W-1:0]    pc,
      input logic [INSTR_W-1:0] instr,
      input logic [PC_W-1:0]    pre_pc,
      input logic               wb_wen,
      input logic [RD_W-1:0]    wb_rd,
      input logic [DATA_W-1:0]  wb_data
   );
      retire_rec_t r;
      r.pc     = pc;
      r.instr  = instr;
      r.pre_pc = pre_pc;
      r.wen    = wb_wen & (wb_rd != '0);
      r.rd     = r.wen ? wb_rd : '0;
      r.data   = r.wen ? wb_data : '0;
      return r;
   endfunction

endpackage

// File: rtl/commit_trace_mem.sv
// commit_trace_mem
//   DEPTH x W register array for the commit trace FIFO.
//   Single synchronous write port, combinational read port, all entries
//   cleared by asynchronous active-high reset.
//   Ports:
//     clk, rst          clock, async active-high reset
//     wr_en/wr_addr/wr_data   write port
//     rd_addr/rd_data         combinational read port
module commit_trace_mem
   import commit_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = REC_W,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Captures one retire record per commit from the W stage and buffers it in
//   a first-word-fall-through FIFO drained by a trace/difftest reader over a
//   valid/ready handshake. Keeps a free-running retired counter (used as the
//   record sequence number) and a sticky overflow flag for dropped records.
//   Ports:
//     clk, rst                        clock, async active-high reset
//     regW_i_*, wb_i_valD             commit-side record inputs
//     trace_i_ready, trace_i_clr_ovf  reader handshake / overflow clear
//     trace_o_valid + head fields     FWFT head record
//     trace_o_count                   occupancy
//     trace_o_retired                 commits since reset
//     trace_o_overflow                sticky drop indicator
//   Build option: COMMIT_TRACE_STALL_EN adds registered output trace_o_stall,
//   high when next-cycle occupancy >= DEPTH-2. Without it the block is lossy
//   under backpressure.
module commit_trace_fifo
   import commit_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SEQ_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     regW_i_commit,
   input  logic [PC_W-1:0]          regW_i_pc,
   input  logic [INSTR_W-1:0]       regW_i_instr,
   input  logic [PC_W-1:0]          regW_i_pre_pc,
   input  logic                     regW_i_wb_reg_wen,
   input  logic [RD_W-1:0]          regW_i_wb_rd,
   input  logic [DATA_W-1:0]        wb_i_valD,
   input  logic                     trace_i_ready,
   input  logic                     trace_i_clr_ovf,
   output logic                     trace_o_valid,
   output logic [PC_W-1:0]          trace_o_pc,
   output logic [INSTR_W-1:0]       trace_o_instr,
   output logic [PC_W-1:0]          trace_o_pre_pc,
   output logic                     trace_o_wen,
   output logic [RD_W-1:0]          trace_o_rd,
   output logic [DATA_W-1:0]        trace_o_data,
   output logic [SEQ_W-1:0]         trace_o_seq,
   output logic [$clog2(DEPTH):0]   trace_o_count,
   output logic [SEQ_W-1:0]         trace_o_retired,
   output logic                     trace_o_overflow
`ifdef COMMIT_TRACE_STALL_EN
  ,output logic                     trace_o_stall
`endif
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned ENT_W = SEQ_W + REC_W;

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [SEQ_W-1:0] retired_q, retired_d;
   logic             ovf_q, ovf_d;

   logic             empty, full, pop, push, drop;
   logic [ENT_W-1:0] wr_entry, rd_entry;
   retire_rec_t      head_rec;

   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      pop   = !empty && trace_i_ready;
      // A same-cycle pop frees the slot, so a commit into a full FIFO is only
      // lost when the reader is not draining.
      push  = regW_i_commit && (!full || pop);
      drop  = regW_i_commit && full && !pop;

      wptr_d    = wptr_q + PW'(push);
      rptr_d    = rptr_q + PW'(pop);
      retired_d = retired_q + SEQ_W'(regW_i_commit);

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (trace_i_clr_ovf) begin
         ovf_d = 1'b0;
      end

      wr_entry = {retired_q, make_rec(regW_i_pc, regW_i_instr, regW_i_pre_pc,
                                      regW_i_wb_reg_wen, regW_i_wb_rd, wb_i_valD)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         retired_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         retired_q <= retired_d;
         ovf_q     <= ovf_d;
      end
   end

   commit_trace_mem #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_addr (wptr_q[AW-1:0]),
      .wr_data (wr_entry),
      .rd_addr (rptr_q[AW-1:0]),
      .rd_data (rd_entry)
   );

   assign head_rec         = rd_entry[REC_W-1:0];
   assign trace_o_seq      = rd_entry[ENT_W-1:REC_W];
   assign trace_o_pc       = head_rec.pc;
   assign trace_o_instr    = head_rec.instr;
   assign trace_o_pre_pc   = head_rec.pre_pc;
   assign trace_o_wen      = head_rec.wen;
   assign trace_o_rd       = head_rec.rd;
   assign trace_o_data     = head_rec.data;
   assign trace_o_valid    = !empty;
   assign trace_o_count    = wptr_q - rptr_q;
   assign trace_o_retired  = retired_q;
   assign trace_o_overflow = ovf_q;

`ifdef COMMIT_TRACE_STALL_EN
   logic          stall_q, stall_d;
   logic [PW-1:0] occ_next;

   // Registered from next-cycle occupancy so the pipeline sees the request
   // while two slots of headroom remain.
   always_comb begin
      occ_next = wptr_d - rptr_d;
      stall_d  = (occ_next >= PW'(DEPTH - 2));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign trace_o_stall = stall_q;
`else
   // Lossy build: no backpressure output; drops are reported via overflow.
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        regW_i_commit = 1'b0;
   logic [31:0] regW_i_pc = '0;
   logic [31:0] regW_i_instr = '0;
   logic [31:0] regW_i_pre_pc = '0;
   logic        regW_i_wb_reg_wen = 1'b0;
   logic [4:0]  regW_i_wb_rd = '0;
   logic [31:0] wb_i_valD = '0;
   logic        trace_i_ready = 1'b0;
   logic        trace_i_clr_ovf = 1'b0;
   logic        trace_o_valid;
   logic [31:0] trace_o_pc, trace_o_instr, trace_o_pre_pc, trace_o_data;
   logic        trace_o_wen;
   logic [4:0]  trace_o_rd;
   logic [31:0] trace_o_seq;
   logic [3:0]  trace_o_count;
   logic [31:0] trace_o_retired;
   logic        trace_o_overflow;
`ifdef COMMIT_TRACE_STALL_EN
   logic        trace_o_stall;
`endif

   always #5 clk = ~clk;

   commit_trace_fifo #(
      .DEPTH (DEPTH),
      .SEQ_W (32)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .regW_i_commit     (regW_i_commit),
      .regW_i_pc         (regW_i_pc),
      .regW_i_instr      (regW_i_instr),
      .regW_i_pre_pc     (regW_i_pre_pc),
      .regW_i_wb_reg_wen (regW_i_wb_reg_wen),
      .regW_i_wb_rd      (regW_i_wb_rd),
      .wb_i_valD         (wb_i_valD),
      .trace_i_ready     (trace_i_ready),
      .trace_i_clr_ovf   (trace_i_clr_ovf),
      .trace_o_valid     (trace_o_valid),
      .trace_o_pc        (trace_o_pc),
      .trace_o_instr     (trace_o_instr),
      .trace_o_pre_pc    (trace_o_pre_pc),
      .trace_o_wen       (trace_o_wen),
      .trace_o_rd        (trace_o_rd),
      .trace_o_data      (trace_o_data),
      .trace_o_seq       (trace_o_seq),
      .trace_o_count     (trace_o_count),
      .trace_o_retired   (trace_o_retired),
      .trace_o_overflow  (trace_o_overflow)
`ifdef COMMIT_TRACE_STALL_EN
     ,.trace_o_stall     (trace_o_stall)
`endif
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pre_pc;
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] seq;
   } exp_rec_t;

   exp_rec_t    sb_q[$];
   logic [31:0] m_retired = '0;
   logic        m_ovf = 1'b0;

   typedef struct {
      bit          c;
      logic [31:0] pc;
      bit          w;
      logic [4:0]  rd;
      logic [31:0] d;
      bit          rdy;
      bit          clr;
      int unsigned e_cnt;
      int unsigned e_ret;
      bit          e_val;
      bit          e_ovf;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, check head against scoreboard front, update the
   // reference model, advance past the edge, check occupancy/counters/flag.
   task automatic cycle(input bit c, input logic [31:0] pc, input bit w,
                        input logic [4:0] rd, input logic [31:0] d,
                        input bit rdy, input bit clr);
      exp_rec_t e;
      bit       drop;
      regW_i_commit     = c;
      regW_i_pc         = pc;
      regW_i_instr      = pc ^ 32'h0000_0013;
      regW_i_pre_pc     = pc + 32'd4;
      regW_i_wb_reg_wen = w;
      regW_i_wb_rd      = rd;
      wb_i_valD         = d;
      trace_i_ready     = rdy;
      trace_i_clr_ovf   = clr;
      #1;
      chk("valid", 64'(trace_o_valid), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
         chk("head_pc_seq", {trace_o_pc, trace_o_seq}, {sb_q[0].pc, sb_q[0].seq});
         chk("head_instr_prepc", {trace_o_instr, trace_o_pre_pc}, {sb_q[0].instr, sb_q[0].pre_pc});
         chk("head_wb", {trace_o_wen, trace_o_rd, trace_o_data},
             {sb_q[0].wen, sb_q[0].rd, sb_q[0].data});
      end
      if (rdy && sb_q.size() != 0) begin
         void'(sb_q.pop_front());
      end
      drop = 1'b0;
      if (c) begin
         if (sb_q.size() < DEPTH) begin
            e.pc     = pc;
            e.instr  = pc ^ 32'h0000_0013;
            e.pre_pc = pc + 32'd4;
            e.wen    = w && (rd != 5'd0);
            e.rd     = e.wen ? rd : 5'd0;
            e.data   = e.wen ? d : 32'd0;
            e.seq    = m_retired;
            sb_q.push_back(e);
         end else begin
            drop = 1'b1;
         end
         m_retired = m_retired + 32'd1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(posedge clk);
      #1;
      regW_i_commit   = 1'b0;
      trace_i_ready   = 1'b0;
      trace_i_clr_ovf = 1'b0;
      chk("count", 64'(trace_o_count), 64'(sb_q.size()));
      chk("retired", 64'(trace_o_retired), 64'(m_retired));
      chk("overflow", 64'(trace_o_overflow), 64'(m_ovf));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", 64'(trace_o_valid), 64'd0);
      chk("rst_count", 64'(trace_o_count), 64'd0);
      chk("rst_retired", 64'(trace_o_retired), 64'd0);
      chk("rst_overflow", 64'(trace_o_overflow), 64'd0);
      chk("rst_pc_seq", {trace_o_pc, trace_o_seq}, 64'd0);
      chk("rst_instr_prepc", {trace_o_instr, trace_o_pre_pc}, 64'd0);
      chk("rst_wb", 64'({trace_o_wen, trace_o_rd, trace_o_data}), 64'd0);
`ifdef COMMIT_TRACE_STALL_EN
      chk("rst_stall", 64'(trace_o_stall), 64'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      m_retired = '0;
      m_ovf = 1'b0;
   endtask

   initial begin
      logic [31:0] tail_seq;

      //            c  pc            w  rd     d             rdy clr cnt ret val ovf
      tbl[0]  = '{1, 32'h8000_0000, 1, 5'd1, 32'h11,        0, 0,  1,  1,  1,  0};
      tbl[1]  = '{1, 32'h8000_0004, 1, 5'd2, 32'h22,        0, 0,  2,  2,  1,  0};
      tbl[2]  = '{1, 32'h8000_0008, 1, 5'd3, 32'h33,        0, 0,  3,  3,  1,  0};
      tbl[3]  = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0,  2,  3,  1,  0};
      tbl[4]  = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0,  1,  3,  1,  0};
      tbl[5]  = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0,  0,  3,  0,  0};
      tbl[6]  = '{1, 32'h8000_000C, 1, 5'd0, 32'h0000_DEAD, 0, 0,  1,  4,  1,  0};
      tbl[7]  = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0,  0,  4,  0,  0};
      tbl[8]  = '{1, 32'h8000_0010, 1, 5'd4, 32'h44,        1, 0,  1,  5,  1,  0};
      tbl[9]  = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 0,  0,  5,  0,  0};
      tbl[10] = '{1, 32'h8000_0014, 0, 5'd7, 32'h77,        0, 0,  1,  6,  1,  0};
      tbl[11] = '{0, 32'h0,         0, 5'd0, 32'h0,         1, 1,  0,  6,  0,  0};

      #2;
      do_reset();

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].c, tbl[i].pc, tbl[i].w, tbl[i].rd, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("tbl%0d_count", i), 64'(trace_o_count), 64'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_retired", i), 64'(trace_o_retired), 64'(tbl[i].e_ret));
         chk($sformatf("tbl%0d_valid", i), 64'(trace_o_valid), 64'(tbl[i].e_val));
         chk($sformatf("tbl%0d_ovf", i), 64'(trace_o_overflow), 64'(tbl[i].e_ovf));
         if (i == 2) chk("tbl_head_pc", 64'(trace_o_pc), 64'h8000_0000);
         if (i == 6) chk("tbl_x0_wb", 64'({trace_o_wen, trace_o_rd, trace_o_data}), 64'd0);
      end

      // Overflow: fill, drop two, drain, observe gap in seq.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(1, 32'h0000_1000 + 32'(4 * i), 1, 5'd5, 32'(i), 0, 0);
      end
      chk("ovf_count", 64'(trace_o_count), 64'd8);
      chk("ovf_flag", 64'(trace_o_overflow), 64'd1);
      chk("ovf_retired", 64'(trace_o_retired), 64'd10);
      for (int i = 0; i < 7; i++) cycle(0, '0, 0, '0, '0, 1, 0);
      chk("last_seq", 64'(trace_o_seq), 64'd7);
      cycle(0, '0, 0, '0, '0, 1, 0);
      cycle(1, 32'h0000_2000, 1, 5'd6, 32'h66, 0, 0);
      chk("seq_after_gap", 64'(trace_o_seq), 64'd10);
      cycle(0, '0, 0, '0, '0, 1, 1);
      chk("ovf_cleared", 64'(trace_o_overflow), 64'd0);

      // Drop and clear in the same cycle: set wins.
      for (int i = 0; i < 8; i++) cycle(1, 32'h0000_3000 + 32'(4 * i), 1, 5'd8, 32'(i), 0, 0);
      cycle(1, 32'h0000_3100, 1, 5'd8, 32'h99, 0, 1);
      chk("set_wins", 64'(trace_o_overflow), 64'd1);
      cycle(0, '0, 0, '0, '0, 0, 1);
      chk("clr_only", 64'(trace_o_overflow), 64'd0);

      // Full FIFO, commit and pop together: accepted, no overflow.
      tail_seq = m_retired;
      cycle(1, 32'h0000_4000, 1, 5'd9, 32'hAB, 1, 0);
      chk("full_pop_count", 64'(trace_o_count), 64'd8);
      chk("full_pop_ovf", 64'(trace_o_overflow), 64'd0);
      for (int i = 0; i < 7; i++) cycle(0, '0, 0, '0, '0, 1, 0);
      chk("tail_seq", 64'(trace_o_seq), 64'(tail_seq));
      chk("tail_seq_rel", 64'(trace_o_seq), 64'(trace_o_retired - 32'd1));
      cycle(0, '0, 0, '0, '0, 1, 0);

      // Sustained push+pop throughput.
      for (int i = 0; i < 6; i++) cycle(1, 32'h0000_5000 + 32'(4 * i), 1, 5'd10, 32'(i + 100), 1, 0);
      chk("stream_count", 64'(trace_o_count), 64'd1);
      cycle(0, '0, 0, '0, '0, 1, 0);

`ifdef COMMIT_TRACE_STALL_EN
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 32'h0000_6000 + 32'(4 * i), 1, 5'd11, 32'(i), 0, 0);
      chk("stall_at5", 64'(trace_o_stall), 64'd0);
      cycle(1, 32'h0000_6014, 1, 5'd11, 32'h5, 0, 0);
      chk("stall_at6", 64'(trace_o_stall), 64'd1);
`endif

      // Asynchronous reset mid-burst with five records buffered.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 32'h0000_7000 + 32'(4 * i), 1, 5'd12, 32'(i), 0, 0);
      chk("pre_rst_count", 64'(trace_o_count), 64'd5);
      #2;
      do_reset();
      cycle(1, 32'h0000_8000, 1, 5'd13, 32'h55, 0, 0);
      cycle(0, '0, 0, '0, '0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
